// File: rtl/flash_op_sequencer.sv
// Expands user flash ops (read / page program / sector erase / status read) into
// WREN + main command + RDSR polling chains on top of the single-command controller.
module flash_op_sequencer #(
  parameter int ADDR_W   = 24,
  parameter int LEN_W    = 9,
  parameter int POLL_GAP = 1024,
  parameter int POLL_MAX = 4096
) (
  input  logic              crystalClk,
  input  logic              sysRst,
  input  logic              opStart,
  input  logic [1:0]        opType,
  input  logic [ADDR_W-1:0] opAddr,
  input  logic [LEN_W-1:0]  opLen,
  output logic              opBusy,
  output logic              opDone,
  output logic              opError,
  output logic [7:0]        statusReg,
  input  logic [7:0]        usrWrData,
  output logic              usrWrReady,
  output logic [7:0]        usrRdData,
  output logic              usrRdValid,
  output logic              cmdStart,
  output logic [7:0]        cmdOpcode,
  output logic [ADDR_W-1:0] cmdAddr,
  output logic              cmdHasAddr,
  output logic              cmdIsWrite,
  output logic [LEN_W-1:0]  cmdLen,
  input  logic              cmdHasFinished,
  input  logic              WrDataReady,
  output logic [7:0]        wr_data,
  input  logic              RdDataValid,
  input  logic [7:0]        rd_data
);
  localparam int PCW = $clog2(POLL_MAX + 1);
  localparam int GCW = $clog2(POLL_GAP + 1);
  localparam logic [1:0] T_READ = 2'b00, T_PROG = 2'b01, T_ERASE = 2'b10, T_STAT = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_WREN, S_WREN_WAIT, S_MAIN, S_MAIN_WAIT, S_POLL, S_POLL_WAIT, S_GAP, S_DONE
  } state_t;

  state_t              state_q;
  logic [1:0]          type_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [PCW-1:0]      pollCnt_q;
  logic [GCW-1:0]      gapCnt_q;
  logic                opBusy_q, opDone_q, opError_q, usrRdValid_q, cmdStart_q;
  logic                cmdHasAddr_q, cmdIsWrite_q;
  logic [7:0]          statusReg_q, usrRdData_q, cmdOpcode_q;
  logic [ADDR_W-1:0]   cmdAddr_q;
  logic [LEN_W-1:0]    cmdLen_q;

  // Main command fields; in IDLE they come straight from the request being accepted.
  logic [1:0]          srcType;
  logic [ADDR_W-1:0]   srcAddr;
  logic [LEN_W-1:0]    srcLen;
  logic [7:0]          mOp;
  logic                mHasAddr, mIsWr;
  logic [ADDR_W-1:0]   mAddr;
  logic [LEN_W-1:0]    mLen;
  logic                mainRd, statLoad, pollWip;

  always_comb begin
    srcType  = (state_q == S_IDLE) ? opType : type_q;
    srcAddr  = (state_q == S_IDLE) ? opAddr : addr_q;
    srcLen   = (state_q == S_IDLE) ? opLen  : len_q;
    mOp      = 8'h03;
    mHasAddr = 1'b1;
    mIsWr    = 1'b0;
    mLen     = srcLen;
    case (srcType)
      T_PROG:  begin mOp = 8'h02; mIsWr = 1'b1; end
      T_ERASE: begin mOp = 8'h20; mLen = '0; end
      T_STAT:  begin mOp = 8'h05; mHasAddr = 1'b0; mLen = LEN_W'(1); end
      default: ;
    endcase
    mAddr    = mHasAddr ? srcAddr : '0;
    mainRd   = (state_q == S_MAIN_WAIT) && (type_q == T_READ || type_q == T_STAT);
    statLoad = RdDataValid && ((state_q == S_POLL_WAIT) ||
               (state_q == S_MAIN_WAIT && type_q == T_STAT));
    // A status byte arriving with the finish pulse decides WIP directly.
    pollWip  = RdDataValid ? rd_data[0] : statusReg_q[0];
  end

  always_ff @(posedge crystalClk or posedge sysRst) begin
    if (sysRst) begin
      state_q      <= S_IDLE;
      type_q       <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      pollCnt_q    <= '0;
      gapCnt_q     <= '0;
      opBusy_q     <= 1'b0;
      opDone_q     <= 1'b0;
      opError_q    <= 1'b0;
      usrRdValid_q <= 1'b0;
      usrRdData_q  <= '0;
      statusReg_q  <= '0;
      cmdStart_q   <= 1'b0;
      cmdOpcode_q  <= '0;
      cmdAddr_q    <= '0;
      cmdHasAddr_q <= 1'b0;
      cmdIsWrite_q <= 1'b0;
      cmdLen_q     <= '0;
    end else begin
      cmdStart_q   <= 1'b0;
      opDone_q     <= 1'b0;
      opError_q    <= 1'b0;
      usrRdValid_q <= RdDataValid && mainRd;
      if (RdDataValid && mainRd) usrRdData_q <= rd_data;
      if (statLoad) statusReg_q <= rd_data;
      case (state_q)
        S_IDLE: if (opStart) begin
          type_q    <= opType;
          addr_q    <= opAddr;
          len_q     <= opLen;
          opBusy_q  <= 1'b1;
          pollCnt_q <= '0;
          if ((opType == T_READ || opType == T_PROG) && opLen == '0) begin
            state_q <= S_DONE; opDone_q <= 1'b1;
          end else if (opType == T_PROG || opType == T_ERASE) begin
            state_q <= S_WREN; cmdStart_q <= 1'b1; cmdOpcode_q <= 8'h06;
            cmdAddr_q <= '0; cmdHasAddr_q <= 1'b0; cmdIsWrite_q <= 1'b0; cmdLen_q <= '0;
          end else begin
            state_q <= S_MAIN; cmdStart_q <= 1'b1; cmdOpcode_q <= mOp;
            cmdAddr_q <= mAddr; cmdHasAddr_q <= mHasAddr; cmdIsWrite_q <= mIsWr; cmdLen_q <= mLen;
          end
        end
        S_WREN: state_q <= S_WREN_WAIT;
        S_WREN_WAIT: if (cmdHasFinished) begin
          state_q <= S_MAIN; cmdStart_q <= 1'b1; cmdOpcode_q <= mOp;
          cmdAddr_q <= mAddr; cmdHasAddr_q <= mHasAddr; cmdIsWrite_q <= mIsWr; cmdLen_q <= mLen;
        end
        S_MAIN: state_q <= S_MAIN_WAIT;
        S_MAIN_WAIT: if (cmdHasFinished) begin
          if (type_q == T_PROG || type_q == T_ERASE) begin
            state_q <= S_POLL; pollCnt_q <= pollCnt_q + 1'b1; cmdStart_q <= 1'b1;
            cmdOpcode_q <= 8'h05; cmdAddr_q <= '0; cmdHasAddr_q <= 1'b0;
            cmdIsWrite_q <= 1'b0; cmdLen_q <= LEN_W'(1);
          end else begin
            state_q <= S_DONE; opDone_q <= 1'b1;
          end
        end
        S_POLL: state_q <= S_POLL_WAIT;
        S_POLL_WAIT: if (cmdHasFinished) begin
          if (!pollWip) begin
            state_q <= S_DONE; opDone_q <= 1'b1;
          end else if (pollCnt_q == PCW'(POLL_MAX)) begin
            state_q <= S_DONE; opDone_q <= 1'b1; opError_q <= 1'b1;
          end else begin
            state_q <= S_GAP; gapCnt_q <= '0;
          end
        end
        S_GAP: begin
          if (gapCnt_q == GCW'(POLL_GAP - 1)) begin
            state_q <= S_POLL; pollCnt_q <= pollCnt_q + 1'b1; cmdStart_q <= 1'b1;
            cmdOpcode_q <= 8'h05; cmdAddr_q <= '0; cmdHasAddr_q <= 1'b0;
            cmdIsWrite_q <= 1'b0; cmdLen_q <= LEN_W'(1);
          end else begin
            gapCnt_q <= gapCnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q  <= S_IDLE;
          opBusy_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign opBusy     = opBusy_q;
  assign opDone     = opDone_q;
  assign opError    = opError_q;
  assign statusReg  = statusReg_q;
  assign usrRdData  = usrRdData_q;
  assign usrRdValid = usrRdValid_q;
  assign cmdStart   = cmdStart_q;
  assign cmdOpcode  = cmdOpcode_q;
  assign cmdAddr    = cmdAddr_q;
  assign cmdHasAddr = cmdHasAddr_q;
  assign cmdIsWrite = cmdIsWrite_q;
  assign cmdLen     = cmdLen_q;
  assign wr_data    = usrWrData;
  assign usrWrReady = WrDataReady && (state_q == S_MAIN_WAIT) && (type_q == T_PROG);
endmodule

// File: tb/tb_flash_op_sequencer.sv
// Directed bench: a small reactive controller model answers each cmdStart.
module tb_flash_op_sequencer;
  localparam int AW = 24, LW = 9, PG = 8, PM = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic          opStart = 1'b0;
  logic [1:0]    opType = '0;
  logic [AW-1:0] opAddr = '0;
  logic [LW-1:0] opLen = '0;
  logic          opBusy, opDone, opError, usrWrReady, usrRdValid;
  logic [7:0]    statusReg, usrRdData, cmdOpcode, wr_data;
  logic [7:0]    usrWrData = '0, rd_data = '0;
  logic          cmdStart, cmdHasAddr, cmdIsWrite;
  logic [AW-1:0] cmdAddr;
  logic [LW-1:0] cmdLen;
  logic          cmdHasFinished = 1'b0, WrDataReady = 1'b0, RdDataValid = 1'b0;

  flash_op_sequencer #(.ADDR_W(AW), .LEN_W(LW), .POLL_GAP(PG), .POLL_MAX(PM)) u_dut (
    .crystalClk(clk), .sysRst(rst),
    .opStart(opStart), .opType(opType), .opAddr(opAddr), .opLen(opLen),
    .opBusy(opBusy), .opDone(opDone), .opError(opError), .statusReg(statusReg),
    .usrWrData(usrWrData), .usrWrReady(usrWrReady), .usrRdData(usrRdData), .usrRdValid(usrRdValid),
    .cmdStart(cmdStart), .cmdOpcode(cmdOpcode), .cmdAddr(cmdAddr), .cmdHasAddr(cmdHasAddr),
    .cmdIsWrite(cmdIsWrite), .cmdLen(cmdLen), .cmdHasFinished(cmdHasFinished),
    .WrDataReady(WrDataReady), .wr_data(wr_data), .RdDataValid(RdDataValid), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int doneCnt = 0, doneCyc = 0, finCyc = 0;
  logic errSeen = 1'b0;
  logic [7:0]    opq[$], rdcap[$], wrcap[$], wq[$], rdq[$], ex[$];
  logic [AW-1:0] adq[$];
  logic [LW-1:0] lnq[$];
  logic [1:0]    flq[$];
  int            pollCyc[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_seq(input string tag, input logic [7:0] q[$], input logic [7:0] e[$]);
    chk({tag, "_len"}, 64'(q.size()), 64'(e.size()));
    for (int i = 0; i < e.size(); i++)
      chk(tag, (i < q.size()) ? q[i] : 8'hxx, e[i]);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Observe everything at the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (cmdStart) begin
      opq.push_back(cmdOpcode); adq.push_back(cmdAddr); lnq.push_back(cmdLen);
      flq.push_back({cmdHasAddr, cmdIsWrite});
      if (cmdOpcode == 8'h05) pollCyc.push_back(cyc);
    end
    if (usrRdValid) rdcap.push_back(usrRdData);
    if (usrWrReady) begin
      wrcap.push_back(wr_data);
      usrWrData = (wq.size() > 0) ? wq.pop_front() : 8'h00;
    end
    if (cmdHasFinished) finCyc = cyc;
    if (opDone) begin doneCnt++; doneCyc = cyc; errSeen = opError; end
  end

  // Controller model: reads return back-to-back bytes with finish on the last one.
  initial begin
    int n;
    logic w;
    forever begin
      @(negedge clk);
      if (cmdStart && !rst) begin
        n = int'(cmdLen); w = cmdIsWrite;
        step();
        if (n == 0) begin
          cmdHasFinished = 1'b1; step(); cmdHasFinished = 1'b0;
        end else if (w) begin
          WrDataReady = 1'b1; repeat (n) step(); WrDataReady = 1'b0;
          cmdHasFinished = 1'b1; step(); cmdHasFinished = 1'b0;
        end else begin
          for (int i = 0; i < n; i++) begin
            RdDataValid = 1'b1;
            rd_data = (rdq.size() > 0) ? rdq.pop_front() : 8'h00;
            cmdHasFinished = (i == n - 1);
            step();
          end
          RdDataValid = 1'b0; cmdHasFinished = 1'b0;
        end
      end
    end
  end

  task automatic clr();
    opq.delete(); adq.delete(); lnq.delete(); flq.delete(); pollCyc.delete();
    rdcap.delete(); wrcap.delete(); wq.delete(); rdq.delete();
    doneCnt = 0; errSeen = 1'b0;
  endtask

  task automatic start_op(input logic [1:0] t, input logic [AW-1:0] a, input logic [LW-1:0] l);
    opType = t; opAddr = a; opLen = l; opStart = 1'b1;
    step();
    opStart = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (doneCnt == 0 && k < 2000) begin step(); k++; end
    chk({tag, "_done_seen"}, 64'(doneCnt > 0), 64'd1);
    repeat (3) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk("rst_busy", opBusy, 0);
    chk("rst_cmdStart", cmdStart, 0);
    chk("rst_done", opDone, 0);
    chk("rst_status", statusReg, 0);
    chk("rst_rdvalid", usrRdValid, 0);
    step(); rst = 1'b0; step();

    // Read 4 bytes
    clr(); rdq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    start_op(2'b00, 24'h001000, 9'd4);
    wait_done("rd");
    ex = '{8'h03}; chk_seq("rd_ops", opq, ex);
    chk("rd_addr", adq[0], 24'h001000);
    chk("rd_len", lnq[0], 4);
    chk("rd_flags", flq[0], 2'b10);
    ex = '{8'hA1, 8'hB2, 8'hC3, 8'hD4}; chk_seq("rd_data", rdcap, ex);
    chk("rd_done_lat", 64'(doneCyc - finCyc), 1);
    chk("rd_donecnt", 64'(doneCnt), 1);
    chk("rd_err", errSeen, 0);
    chk("rd_idle_busy", opBusy, 0);

    // Program 2 bytes, WIP clears on third poll
    clr(); usrWrData = 8'h5A; wq = '{8'hA5}; rdq = '{8'h03, 8'h03, 8'h00};
    start_op(2'b01, 24'h002100, 9'd2);
    wait_done("pg");
    ex = '{8'h06, 8'h02, 8'h05, 8'h05, 8'h05}; chk_seq("pg_ops", opq, ex);
    chk("pg_main_len", lnq[1], 2);
    chk("pg_main_flags", flq[1], 2'b11);
    ex = '{8'h5A, 8'hA5}; chk_seq("pg_wr", wrcap, ex);
    chk("pg_polls", 64'(pollCyc.size()), 3);
    chk("pg_gap1", 64'(pollCyc[1] - pollCyc[0]), 64'(PG + 2));
    chk("pg_gap2", 64'(pollCyc[2] - pollCyc[1]), 64'(PG + 2));
    chk("pg_rdcap_none", 64'(rdcap.size()), 0);
    chk("pg_err", errSeen, 0);
    chk("pg_status", statusReg, 8'h00);

    // Erase with WIP stuck: exactly POLL_MAX polls then error
    clr(); rdq = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    start_op(2'b10, 24'h003000, 9'd0);
    wait_done("er");
    ex = '{8'h06, 8'h20, 8'h05, 8'h05, 8'h05, 8'h05}; chk_seq("er_ops", opq, ex);
    chk("er_addr", adq[1], 24'h003000);
    chk("er_len", lnq[1], 0);
    chk("er_err", errSeen, 1);
    chk("er_donecnt", 64'(doneCnt), 1);
    chk("er_status", statusReg, 8'h01);

    // opStart while busy is dropped
    clr(); rdq = '{8'h11, 8'h22};
    start_op(2'b00, 24'h000040, 9'd2);
    opType = 2'b01; opLen = 9'd3; opStart = 1'b1; step(); opStart = 1'b0;
    wait_done("bz");
    ex = '{8'h03}; chk_seq("bz_ops", opq, ex);
    ex = '{8'h11, 8'h22}; chk_seq("bz_data", rdcap, ex);

    // Zero-length program: done, no commands
    clr();
    start_op(2'b01, 24'h000000, 9'd0);
    wait_done("z");
    chk("z_cmds", 64'(opq.size()), 0);
    chk("z_donecnt", 64'(doneCnt), 1);
    chk("z_err", errSeen, 0);
    chk("z_busy", opBusy, 0);

    // Status read
    clr(); rdq = '{8'h1C};
    start_op(2'b11, 24'h000055, 9'd0);
    wait_done("st");
    ex = '{8'h05}; chk_seq("st_ops", opq, ex);
    chk("st_len", lnq[0], 1);
    chk("st_flags", flq[0], 2'b00);
    chk("st_addr", adq[0], 0);
    ex = '{8'h1C}; chk_seq("st_data", rdcap, ex);
    chk("st_status", statusReg, 8'h1C);

    // Reset in the middle of a program op
    clr(); usrWrData = 8'h77; wq = '{8'h88};
    start_op(2'b01, 24'h002000, 9'd2);
    repeat (2) step();
    chk("mr_pre_busy", opBusy, 1);
    chk("mr_pre_cmd", cmdOpcode, 8'h02);
    rst = 1'b1; #1;
    chk("mr_busy", opBusy, 0);
    chk("mr_cmdStart", cmdStart, 0);
    chk("mr_opcode", cmdOpcode, 0);
    chk("mr_len", cmdLen, 0);
    repeat (5) step();
    rst = 1'b0;
    clr();
    repeat (30) step();
    chk("mr_post_busy", opBusy, 0);
    chk("mr_post_cmds", 64'(opq.size()), 0);
    chk("mr_post_done", 64'(doneCnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
